// File: rtl/ysyx22041405_wbu.sv
// Writeback unit: LSU-priority arbitration of EXU/LSU results into one registered
// regfile write port, plus the per-register busy scoreboard used for RAW stalls.
module ysyx22041405_wbu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [4:0]       alu_rd,
   input  logic             alu_wen,
   input  logic [WIDTH-1:0] alu_data,
   input  logic             lsu_valid,
   output logic             lsu_ready,
   input  logic [4:0]       lsu_rd,
   input  logic             lsu_wen,
   input  logic [2:0]       lsu_funct3,
   input  logic [1:0]       lsu_addr_lo,
   input  logic [WIDTH-1:0] lsu_data,
   input  logic             issue_valid,
   input  logic [4:0]       issue_rd,
   input  logic             issue_wen,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   output logic             busy1,
   output logic             busy2,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [WIDTH-1:0] rf_wdata,
   output logic             commit_valid
);

   logic [31:0]      busy;
   logic [31:0]      busy_nxt;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [WIDTH-1:0] load_data;
   logic             take;
   logic [4:0]       sel_rd;
   logic             sel_wen;
   logic [WIDTH-1:0] sel_data;

   assign lsu_ready = 1'b1;
   assign alu_ready = !lsu_valid;

   always_comb begin
      ld_byte = lsu_data[7:0];
      case (lsu_addr_lo)
         2'd1:    ld_byte = lsu_data[15:8];
         2'd2:    ld_byte = lsu_data[23:16];
         2'd3:    ld_byte = lsu_data[31:24];
         default: ld_byte = lsu_data[7:0];
      endcase
      // Half select ignores addr bit 0; misaligned halves are not split.
      ld_half = lsu_addr_lo[1] ? lsu_data[31:16] : lsu_data[15:0];
      case (lsu_funct3)
         3'd0:    load_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
         3'd1:    load_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
         3'd4:    load_data = {{(WIDTH-8){1'b0}}, ld_byte};
         3'd5:    load_data = {{(WIDTH-16){1'b0}}, ld_half};
         default: load_data = lsu_data;
      endcase
   end

   always_comb begin
      take     = lsu_valid || alu_valid;
      sel_rd   = lsu_valid ? lsu_rd : alu_rd;
      sel_wen  = lsu_valid ? lsu_wen : alu_wen;
      sel_data = lsu_valid ? load_data : alu_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we        <= 1'b0;
         rf_waddr     <= 5'd0;
         rf_wdata     <= '0;
         commit_valid <= 1'b0;
      end else begin
         commit_valid <= take;
         rf_we        <= take && sel_wen && (sel_rd != 5'd0);
         if (take) begin
            rf_waddr <= sel_rd;
            rf_wdata <= (sel_wen && (sel_rd != 5'd0)) ? sel_data : '0;
         end
      end
   end

   // Set after clear so a re-issue on the retiring edge keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      if (rf_we)
         busy_nxt[rf_waddr] = 1'b0;
      if (issue_valid && issue_wen && (issue_rd != 5'd0))
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   assign busy1 = (rs1 != 5'd0) && busy[rs1];
   assign busy2 = (rs2 != 5'd0) && busy[rs2];

endmodule

// File: tb/tb_ysyx22041405_wbu.sv
// Bench for ysyx22041405_wbu: writes are predicted into a queue when driven and
// checked by a negedge monitor; timing and scoreboard checks are done in each test task.
module tb_ysyx22041405_wbu;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready, alu_wen;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid, lsu_ready, lsu_wen;
   logic [4:0]  lsu_rd;
   logic [2:0]  lsu_funct3;
   logic [1:0]  lsu_addr_lo;
   logic [31:0] lsu_data;
   logic        issue_valid, issue_wen;
   logic [4:0]  issue_rd, rs1, rs2;
   logic        busy1, busy2, rf_we, commit_valid;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   ysyx22041405_wbu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
      .alu_wen(alu_wen), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
      .lsu_wen(lsu_wen), .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
      .lsu_data(lsu_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wen(issue_wen),
      .rs1(rs1), .rs2(rs2), .busy1(busy1), .busy2(busy2),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .commit_valid(commit_valid)
   );

   always @(negedge clk) begin
      if (commit_valid === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_commit: got we=%0b waddr=%0d wdata=%h, expected no commit",
                     rf_we, rf_waddr, rf_wdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({rf_we, rf_waddr, rf_wdata} !== e) begin
               n_bad++;
               $display("FAIL commit_data: got we=%0b waddr=%0d wdata=%h, expected we=%0b waddr=%0d wdata=%h",
                        rf_we, rf_waddr, rf_wdata, e.we, e.waddr, e.wdata);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; alu_wen = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_wen = 0; lsu_rd = 0; lsu_funct3 = 0; lsu_addr_lo = 0; lsu_data = 0;
      issue_valid = 0; issue_wen = 0; issue_rd = 0;
   endtask

   task automatic push(input logic wen, input logic [4:0] rd, input logic [31:0] d);
      exp_t e;
      e.we    = wen && (rd != 0);
      e.waddr = rd;
      e.wdata = e.we ? d : 32'h0;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      idle(); rs1 = 0; rs2 = 0;
      rst = 1;
      tick(); tick();
      n_cmp++;
      if (rf_we !== 1'b0 || commit_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got we=%b commit=%b, expected 0/0", rf_we, commit_valid);
      end
      for (int i = 0; i < 32; i++) begin
         rs1 = i[4:0]; rs2 = 5'(31 - i);
         #1;
         n_cmp++;
         if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: rs1=%0d busy1=%b busy2=%b, expected 0", rs1, busy1, busy2);
         end
      end
      rst = 0;
      tick();
   endtask

   task automatic test_alu_write();
      alu_valid = 1; alu_wen = 1; alu_rd = 5; alu_data = 32'h1234;
      push(1, 5, 32'h1234);
      tick();
      idle();
      n_cmp++;
      if (rf_we !== 1 || rf_waddr !== 5 || rf_wdata !== 32'h1234 || commit_valid !== 1) begin
         n_bad++;
         $display("FAIL alu_latency: got we=%b waddr=%0d wdata=%h commit=%b, expected 1/5/1234/1",
                  rf_we, rf_waddr, rf_wdata, commit_valid);
      end
      tick();
      n_cmp++;
      if (rf_we !== 0 || commit_valid !== 0) begin
         n_bad++;
         $display("FAIL alu_one_cycle: got we=%b commit=%b, expected 0/0", rf_we, commit_valid);
      end
   endtask

   task automatic test_collision();
      lsu_valid = 1; lsu_wen = 1; lsu_rd = 3; lsu_funct3 = 2; lsu_data = 32'hAAAA_0003;
      alu_valid = 1; alu_wen = 1; alu_rd = 4; alu_data = 32'hBBBB_0004;
      #1;
      n_cmp++;
      if (alu_ready !== 0 || lsu_ready !== 1) begin
         n_bad++;
         $display("FAIL collision_ready: got alu_ready=%b lsu_ready=%b, expected 0/1", alu_ready, lsu_ready);
      end
      push(1, 3, 32'hAAAA_0003);
      tick();
      lsu_valid = 0;
      #1;
      n_cmp++;
      if (rf_waddr !== 3 || alu_ready !== 1) begin
         n_bad++;
         $display("FAIL collision_first: got waddr=%0d alu_ready=%b, expected 3/1", rf_waddr, alu_ready);
      end
      push(1, 4, 32'hBBBB_0004);
      tick();
      idle();
      n_cmp++;
      if (rf_we !== 1 || rf_waddr !== 4) begin
         n_bad++;
         $display("FAIL collision_second: got we=%b waddr=%0d, expected 1/4", rf_we, rf_waddr);
      end
      tick();
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3 [10] = '{3'd0, 3'd5, 3'd1, 3'd4, 3'd0, 3'd2, 3'd5, 3'd1, 3'd3, 3'd6};
      logic [1:0]  al [10] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd0};
      logic [31:0] dd [10] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h0000_8001, 32'h1234_5678,
                               32'h0000_A500, 32'hDEAD_BEEF, 32'hFEDC_1234, 32'h1234_F00D,
                               32'hCAFE_BABE, 32'h0BAD_F00D};
      logic [31:0] ex [10] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_8001, 32'h0000_0056,
                               32'hFFFF_FFA5, 32'hDEAD_BEEF, 32'h0000_FEDC, 32'hFFFF_F00D,
                               32'hCAFE_BABE, 32'h0BAD_F00D};
      for (int i = 0; i < 10; i++) begin
         lsu_valid = 1; lsu_wen = 1; lsu_rd = 5'(10 + i);
         lsu_funct3 = f3[i]; lsu_addr_lo = al[i]; lsu_data = dd[i];
         push(1, 5'(10 + i), ex[i]);
         tick();
      end
      lsu_wen = 0; lsu_rd = 9; lsu_data = 32'h7777_7777;
      push(0, 9, 32'h0);
      tick();
      idle();
      tick();
   endtask

   task automatic test_back_to_back();
      alu_valid = 1; alu_wen = 1;
      for (int i = 0; i < 4; i++) begin
         alu_rd = 5'(20 + i); alu_data = 32'h100 * (i + 1);
         push(1, 5'(20 + i), 32'h100 * (i + 1));
         tick();
      end
      alu_rd = 25; alu_data = 32'h5555;
      lsu_valid = 1; lsu_wen = 1; lsu_rd = 26; lsu_funct3 = 2; lsu_data = 32'h2626;
      for (int i = 0; i < 3; i++) begin
         push(1, 26, 32'h2626);
         tick();
      end
      lsu_valid = 0;
      push(1, 25, 32'h5555);
      tick();
      idle();
      tick();
   endtask

   task automatic test_rd0();
      alu_valid = 1; alu_wen = 1; alu_rd = 0; alu_data = 32'h55;
      push(1, 0, 32'h55);
      tick();
      idle();
      n_cmp++;
      if (commit_valid !== 1 || rf_we !== 0) begin
         n_bad++;
         $display("FAIL rd0: got commit=%b we=%b, expected 1/0", commit_valid, rf_we);
      end
      tick();
   endtask

   task automatic test_scoreboard();
      rs1 = 7; rs2 = 8;
      issue_valid = 1; issue_wen = 1; issue_rd = 7;
      tick();
      issue_valid = 0;
      n_cmp++;
      if (busy1 !== 1 || busy2 !== 0) begin
         n_bad++;
         $display("FAIL sb_set: got busy1=%b busy2=%b, expected 1/0", busy1, busy2);
      end
      alu_valid = 1; alu_wen = 1; alu_rd = 7; alu_data = 32'h77;
      push(1, 7, 32'h77);
      tick();
      alu_valid = 0;
      n_cmp++;
      if (busy1 !== 1) begin
         n_bad++;
         $display("FAIL sb_no_bypass: got busy1=%b, expected 1", busy1);
      end
      tick();
      n_cmp++;
      if (busy1 !== 0) begin
         n_bad++;
         $display("FAIL sb_clear: got busy1=%b, expected 0", busy1);
      end
      issue_valid = 1; issue_rd = 7;
      tick();
      issue_valid = 0;
      alu_valid = 1; alu_rd = 7; alu_data = 32'h78;
      push(1, 7, 32'h78);
      tick();
      alu_valid = 0;
      issue_valid = 1; issue_rd = 7;
      tick();
      issue_valid = 0;
      n_cmp++;
      if (busy1 !== 1) begin
         n_bad++;
         $display("FAIL sb_set_wins: got busy1=%b, expected 1", busy1);
      end
      alu_valid = 1; alu_rd = 7; alu_data = 32'h79;
      push(1, 7, 32'h79);
      tick();
      alu_valid = 0;
      tick();
      n_cmp++;
      if (busy1 !== 0) begin
         n_bad++;
         $display("FAIL sb_reclear: got busy1=%b, expected 0", busy1);
      end
      rs1 = 0; rs2 = 12;
      issue_valid = 1; issue_wen = 1; issue_rd = 0;
      tick();
      issue_wen = 0; issue_rd = 12;
      tick();
      issue_valid = 0;
      n_cmp++;
      if (busy1 !== 0 || busy2 !== 0) begin
         n_bad++;
         $display("FAIL sb_rd0_nowen: got busy1=%b busy2=%b, expected 0/0", busy1, busy2);
      end
      idle();
   endtask

   task automatic test_reset_mid();
      rs1 = 13;
      issue_valid = 1; issue_wen = 1; issue_rd = 13;
      alu_valid = 1; alu_wen = 1; alu_rd = 13; alu_data = 32'hD00D;
      push(1, 13, 32'hD00D);
      tick();
      idle();
      rst = 1;
      tick();
      n_cmp++;
      if (rf_we !== 0 || commit_valid !== 0 || busy1 !== 0) begin
         n_bad++;
         $display("FAIL reset_mid: got we=%b commit=%b busy1=%b, expected 0/0/0", rf_we, commit_valid, busy1);
      end
      alu_valid = 1; alu_wen = 1; alu_rd = 14; alu_data = 32'hEEEE;
      lsu_valid = 1; lsu_wen = 1; lsu_rd = 15;
      issue_valid = 1; issue_wen = 1; issue_rd = 14;
      tick();
      idle();
      rst = 0;
      rs1 = 14;
      tick();
      n_cmp++;
      if (rf_we !== 0 || commit_valid !== 0 || busy1 !== 0) begin
         n_bad++;
         $display("FAIL reset_ignores_hs: got we=%b commit=%b busy1=%b, expected 0/0/0", rf_we, commit_valid, busy1);
      end
   endtask

   initial begin
      idle(); rs1 = 0; rs2 = 0; rst = 1;
      test_reset();
      test_alu_write();
      test_collision();
      test_load_ext();
      test_back_to_back();
      test_rd0();
      test_scoreboard();
      test_reset_mid();
      tick(); tick();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL missing_commits: got %0d still pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
